// File: rtl/data_sync_pkg.sv
// Shared definitions for the DataSync consumer path.
package data_sync_pkg;

  // Default data word width, shared with DataSync.
  localparam int unsigned DATA_WIDTH = 4;

  // Acknowledge FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } ack_state_e;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; combinational head read.
module sync_fifo
  import data_sync_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level   = wptr_q - rptr_q;
  assign dout    = mem_q[rptr_q[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer update; full/empty use the state at the start of the cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop_ok)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Storage write; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/data_sync_reader.sv
// DataSync consumer: captures each presented word once, acknowledges it
// with a one-cycle pulse and buffers it for a valid/ready downstream.
module data_sync_reader
  import data_sync_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        sync_data,
  input  logic                    sync_data_valid,
  output logic                    sync_data_retrieved,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [clog2(DEPTH):0]   level
);

  ack_state_e state_q, state_d;
  logic       retrieved_q, retrieved_d;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;

  assign push                = (state_q == IDLE) && sync_data_valid && !fifo_full;
  assign sync_data_retrieved = retrieved_q;
  assign rd_valid            = !fifo_empty;

  // Next-state logic for the acknowledge handshake.
  always_comb begin
    state_d     = state_q;
    retrieved_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (push) begin
          state_d     = ACK;
          retrieved_d = 1'b1;
        end
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!sync_data_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM state and registered acknowledge output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      retrieved_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retrieved_q <= retrieved_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (sync_data),
    .pop     (rd_ready),
    .dout    (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

endmodule

// File: tb/tb_data_sync_reader.sv
// Directed bench for data_sync_reader (WIDTH=4, DEPTH=4).
module tb_data_sync_reader;

  logic       clk;
  logic       reset_n;
  logic [3:0] sync_data;
  logic       sync_data_valid;
  logic       sync_data_retrieved;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] level;

  data_sync_reader #(
    .WIDTH (4),
    .DEPTH (4)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .sync_data           (sync_data),
    .sync_data_valid     (sync_data_valid),
    .sync_data_retrieved (sync_data_retrieved),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .rd_ready            (rd_ready),
    .level               (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [3:0] data;
    logic       ready;
    logic       e_ret;
    logic       e_rv;
    int         e_lvl;
    int         e_data;   // -1: head not checked
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_fail;
  int   exp_q[$];

  task automatic add(input logic r, input logic v, input int d, input logic rdy,
                     input logic er, input logic erv, input int el, input int ed);
    vec_t t;
    t.rst_n = r; t.valid = v; t.data = 4'(d); t.ready = rdy;
    t.e_ret = er; t.e_rv = erv; t.e_lvl = el; t.e_data = ed;
    vecs.push_back(t);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit.
  task automatic cycle(input logic r, input logic v, input int d, input logic rdy);
    reset_n = r; sync_data_valid = v; sync_data = 4'(d); rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    n_cmp = 0; n_fail = 0;
    reset_n = 1'b0; sync_data_valid = 1'b0; sync_data = '0; rd_ready = 1'b0;

    // Reset, single word, held valid, fill/overflow, drain.
    add(0,0,0,0, 0,0,0,-1);
    add(1,1,1,0, 1,1,1,1);
    for (int i = 0; i < 5; i++) add(1,1,1,0, 0,1,1,1);
    add(1,0,0,0, 0,1,1,1);
    add(1,0,0,1, 0,0,0,-1);
    for (int k = 1; k <= 4; k++) begin
      add(1,1,k,0, 1,1,k,1);
      add(1,0,0,0, 0,1,k,1);
      add(1,0,0,0, 0,1,k,1);
    end
    add(1,1,5,0, 0,1,4,1);
    add(1,1,5,0, 0,1,4,1);
    add(1,1,5,1, 0,1,3,2);
    add(1,1,5,0, 1,1,4,2);
    add(1,0,0,0, 0,1,4,2);
    add(1,0,0,0, 0,1,4,2);
    add(1,0,0,1, 0,1,3,3);
    add(1,0,0,1, 0,1,2,4);
    add(1,0,0,1, 0,1,1,5);
    add(1,0,0,1, 0,0,0,-1);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst_n, vecs[i].valid, int'(vecs[i].data), vecs[i].ready);
      check($sformatf("v%0d.retrieved", i), int'(sync_data_retrieved), int'(vecs[i].e_ret));
      check($sformatf("v%0d.rd_valid", i), int'(rd_valid), int'(vecs[i].e_rv));
      check($sformatf("v%0d.level", i), int'(level), vecs[i].e_lvl);
      if (vecs[i].e_data >= 0)
        check($sformatf("v%0d.rd_data", i), int'(rd_data), vecs[i].e_data);
    end

    // Push and pop in the same cycle at level 2; 12 words wrap the pointers.
    for (int k = 1; k <= 2; k++) begin
      cycle(1,1,k,0);
      exp_q.push_back(k);
      cycle(1,0,0,0);
      cycle(1,0,0,0);
    end
    check("pp.level_init", int'(level), 2);
    for (int k = 3; k <= 12; k++) begin
      check($sformatf("pp%0d.head", k), int'(rd_data), exp_q[0]);
      cycle(1,1,k,1);
      void'(exp_q.pop_front());
      exp_q.push_back(k);
      check($sformatf("pp%0d.retrieved", k), int'(sync_data_retrieved), 1);
      check($sformatf("pp%0d.level", k), int'(level), 2);
      cycle(1,0,0,0);
      cycle(1,0,0,0);
    end
    while (exp_q.size() > 0) begin
      check("pp.drain_head", int'(rd_data), exp_q[0]);
      cycle(1,0,0,1);
      void'(exp_q.pop_front());
    end
    check("pp.empty_level", int'(level), 0);
    check("pp.empty_rv", int'(rd_valid), 0);

    // rd_ready while empty must not move pointers.
    cycle(1,0,0,1);
    cycle(1,0,0,1);
    check("empty_pop.level", int'(level), 0);
    cycle(1,1,9,0);
    check("empty_pop.head", int'(rd_data), 9);
    check("empty_pop.level1", int'(level), 1);
    cycle(1,0,0,1);
    cycle(1,0,0,0);
    check("empty_pop.level0", int'(level), 0);

    // Reset during ACK with valid still high, then exactly one re-acknowledge.
    cycle(1,1,7,0);
    check("rst.capture_ret", int'(sync_data_retrieved), 1);
    check("rst.capture_lvl", int'(level), 1);
    cycle(0,1,7,0);
    check("rst.ret_dropped", int'(sync_data_retrieved), 0);
    check("rst.level", int'(level), 0);
    check("rst.rv", int'(rd_valid), 0);
    cycle(1,1,7,0);
    check("rst.recapture_ret", int'(sync_data_retrieved), 1);
    check("rst.recapture_lvl", int'(level), 1);
    check("rst.recapture_data", int'(rd_data), 7);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1,1,7,0);
      pulses += int'(sync_data_retrieved);
    end
    check("rst.no_extra_ack", pulses, 0);
    check("rst.final_level", int'(level), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
